// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU/divider types, select encodings and default width
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_MUL = 2'b10;
  // Reserved for routing to alu_div once an issue unit exists.
  localparam logic [1:0] SEL_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/alu_div_step.sv
// rtl/alu_div_step.sv - one restoring-division step: shift in a dividend bit, trial-subtract, restore
module alu_div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH:0]   prem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   prem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           unused_prem_msb;

  // The partial remainder is always below the divisor, so its top bit is zero on entry.
  assign unused_prem_msb = prem_i[WIDTH];
  assign shifted         = {prem_i[WIDTH-1:0], bit_i};
  assign diff            = shifted - {1'b0, divisor_i};
  assign qbit_o          = (shifted >= {1'b0, divisor_i});
  assign prem_o          = qbit_o ? diff : shifted;

endmodule

// File: rtl/alu_div.sv
// rtl/alu_div.sv - multi-cycle unsigned restoring divider, 2*WIDTH dividend by WIDTH divisor
module alu_div
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out,
  output logic               carry,
  output logic [WIDTH-1:0]   rem,
  output logic               dz
);

  localparam int CNT_W = $clog2(2*WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2*WIDTH-1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH:0]     prem_q, prem_d;
  logic [2*WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     prem_next;
  logic               qbit;
  logic [2*WIDTH-1:0] quo_next;

  alu_div_step #(.WIDTH(WIDTH)) u_step (
    .prem_i    (prem_q),
    .bit_i     (dividend_q[2*WIDTH-1]),
    .divisor_i (divisor_q),
    .prem_o    (prem_next),
    .qbit_o    (qbit)
  );

  assign quo_next = {quo_q[2*WIDTH-2:0], qbit};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    prem_d     = prem_q;
    quo_d      = quo_q;
    out_d      = out_q;
    carry_d    = carry_q;
    rem_d      = rem_q;
    dz_d       = dz_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_RUN: begin
        dividend_d = {dividend_q[2*WIDTH-2:0], 1'b0};
        prem_d     = prem_next;
        quo_d      = quo_next;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = ST_DONE;
          out_d   = quo_next[WIDTH-1:0];
          carry_d = |quo_next[2*WIDTH-1:WIDTH];
          rem_d   = prem_next[WIDTH-1:0];
          dz_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE accept identically, which gives back-to-back issue from DONE.
        if (start) begin
          dividend_d = in1;
          divisor_d  = in2;
          prem_d     = '0;
          quo_d      = '0;
          cnt_d      = '0;
          if (in2 == '0) begin
            state_d = ST_DONE;
            out_d   = '1;
            carry_d = 1'b1;
            rem_d   = in1[WIDTH-1:0];
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      prem_q     <= '0;
      quo_q      <= '0;
      out_q      <= '0;
      carry_q    <= 1'b0;
      rem_q      <= '0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      prem_q     <= prem_d;
      quo_q      <= quo_d;
      out_q      <= out_d;
      carry_q    <= carry_d;
      rem_q      <= rem_d;
      dz_q       <= dz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign out   = out_q;
  assign carry = carry_q;
  assign rem   = rem_q;
  assign dz    = dz_q;

endmodule

// File: tb/tb_alu_div.sv
// tb/tb_alu_div.sv - scoreboard bench for alu_div at WIDTH=4
module tb_alu_div;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [2*W-1:0] in1;
  logic [W-1:0]   in2;
  logic           busy, done, carry, dz;
  logic [W-1:0]   out, rem;

  typedef struct {
    logic [W-1:0] out;
    logic         carry;
    logic [W-1:0] rem;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  alu_div #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .carry (carry),
    .rem   (rem),
    .dz    (dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called just before the accepting edge, so that edge is cycle cyc+1.
  task automatic push_exp(input logic [2*W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int q, r;
    if (b == 0) begin
      e.out = '1; e.carry = 1'b1; e.rem = a[W-1:0]; e.dz = 1'b1; e.due = cyc + 1;
    end else begin
      q = int'(a) / int'(b);
      r = int'(a) % int'(b);
      e.out = q[W-1:0]; e.carry = (q >= (1 << W)); e.rem = r[W-1:0]; e.dz = 1'b0;
      e.due = cyc + 1 + 2*W;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out", 32'(out), 32'(e.out));
        check("carry", 32'(carry), 32'(e.carry));
        check("rem", 32'(rem), 32'(e.rem));
        check("dz", 32'(dz), 32'(e.dz));
        check("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic do_op(input logic [2*W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in1 = a; in2 = b; start = 1'b1;
    push_exp(a, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check(tag, 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_out"}, 32'(out), 32'd0);
    check({tag, "_carry"}, 32'(carry), 32'd0);
    check({tag, "_rem"}, 32'(rem), 32'd0);
    check({tag, "_dz"}, 32'(dz), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in1 = '0; in2 = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'h25, 4'h6);
    check("busy_in_run", 32'(busy), 32'd1);
    drain("drain_25_6");

    do_op(8'h64, 4'h5);
    drain("drain_64_5");
    do_op(8'hff, 4'h1);
    drain("drain_ff_1");

    do_op(8'h3c, 4'h0);
    check("dz_busy_low", 32'(busy), 32'd0);
    drain("drain_dz");
    check("dz_outputs_hold", 32'(out), 32'hf);

    // A start pulse mid-RUN must be ignored; then start is held into DONE.
    do_op(8'h25, 4'h6);
    repeat (2) @(negedge clk);
    in1 = 8'h99; in2 = 4'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in1 = 8'h3c; in2 = 4'h7; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    check("held_start_reached_done", 32'(done), 32'd1);
    push_exp(8'h3c, 4'h7);
    @(negedge clk);
    start = 1'b0;
    drain("drain_b2b");

    // Reset asserted mid-RUN discards the operation.
    do_op(8'h25, 4'h6);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(8'h25, 4'h6);
    drain("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
